// File: rtl/aes_inv_cipher_iter.sv
// -----------------------------------------------------------------------------
// aes_inv_cipher_iter
//
// Iterative AES-128 decryption core. One inverse round is computed per clock
// (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns). Round keys are not
// stored here: the core presents a round-key index and expects the matching
// key back combinationally in the same cycle.
//
// Ports:
//   clk         in   1    clock
//   rst         in   1    synchronous active-high reset
//   in_valid    in   1    ciphertext valid
//   in_ready    out  1    core can accept a ciphertext (IDLE)
//   ciphertext  in   128  block to decrypt, sampled only on the accept edge
//   rk_idx      out  4    round-key index requested (always 0..10)
//   rk          in   128  round key for rk_idx, same-cycle lookup
//   out_valid   out  1    plaintext valid (DONE)
//   out_ready   in   1    downstream accepts plaintext
//   plaintext   out  128  decrypted block (equals the state register)
//
// Byte j of a block (row j%4, column j/4) lives at bits [127-8j -: 8].
// -----------------------------------------------------------------------------

package aes_inv_cipher_iter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_DONE  = 2'd2
   } fsm_e;

   localparam logic [3:0] LAST_RK_IDX = 4'd10;

   // Multiply by x in GF(2^8) modulo 0x11b.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
   endfunction

   // General GF(2^8) multiply, shift-and-add.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         acc = acc ^ (sh & {8{b[i]}});
         sh  = xtime(sh);
      end
      return acc;
   endfunction

   // Multiplicative inverse as x^254 (2+4+...+128); maps 0 to 0 as AES requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] acc;
      logic [7:0] pw;
      acc = 8'h01;
      pw  = x;
      for (int i = 0; i < 7; i++) begin
         pw  = gf_mul(pw, pw);
         acc = gf_mul(acc, pw);
      end
      return acc;
   endfunction

   // Inverse S-box: undo the affine map (rotations 1,3,6 plus 0x05), then invert.
   function automatic logic [7:0] inv_sub_byte(input logic [7:0] b);
      logic [7:0] a;
      a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
      return gf_inv(a);
   endfunction

   // One column through the {0e,0b,0d,09} circulant; row 0 is the MSB byte.
   function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
      logic [7:0] a0;
      logic [7:0] a1;
      logic [7:0] a2;
      logic [7:0] a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
              gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
              gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
              gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
   endfunction

   // Row r rotates right by r columns: out[r][c] = in[r][(c-r) mod 4].
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      int           src;
      o = 128'd0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            src = 4 * ((c - r + 4) % 4) + r;
            o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * src -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = 128'd0;
      for (int j = 0; j < 16; j++) begin
         o[127 - 8 * j -: 8] = inv_sub_byte(s[127 - 8 * j -: 8]);
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      o = 128'd0;
      for (int c = 0; c < 4; c++) begin
         o[127 - 32 * c -: 32] = inv_mix_column(s[127 - 32 * c -: 32]);
      end
      return o;
   endfunction

endpackage

module aes_inv_cipher_iter
   import aes_inv_cipher_iter_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] ciphertext,
   output logic [3:0]   rk_idx,
   input  logic [127:0] rk,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] plaintext
);

   fsm_e         fsm_q;
   fsm_e         fsm_d;
   logic [127:0] state_q;
   logic [127:0] state_d;
   logic [3:0]   round_q;
   logic [3:0]   round_d;

   logic [127:0] sub_s;
   logic [127:0] ark_s;
   logic [127:0] mix_s;

   // Shared inverse-round datapath; the last round simply skips the mix stage.
   assign sub_s = inv_sub_bytes(inv_shift_rows(state_q));
   assign ark_s = sub_s ^ rk;
   assign mix_s = inv_mix_columns(ark_s);

   // State, round counter and FSM registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q   <= ST_IDLE;
         state_q <= 128'd0;
         round_q <= 4'd0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         round_q <= round_d;
      end
   end

   // Next-state logic: initial whitening on accept, then 10 inverse rounds.
   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      round_d = round_q;
      case (fsm_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = ciphertext ^ rk;
               round_d = 4'd9;
               fsm_d   = ST_ROUND;
            end else begin
               fsm_d = ST_IDLE;
            end
         end
         ST_ROUND: begin
            if (round_q == 4'd0) begin
               state_d = ark_s;
               fsm_d   = ST_DONE;
            end else begin
               state_d = mix_s;
               round_d = round_q - 4'd1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               fsm_d = ST_IDLE;
            end else begin
               fsm_d = ST_DONE;
            end
         end
         default: begin
            fsm_d   = ST_IDLE;
            state_d = 128'd0;
            round_d = 4'd0;
         end
      endcase
   end

   // Output decode straight from the registered state; rk_idx stays in 0..10.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      rk_idx    = LAST_RK_IDX;
      case (fsm_q)
         ST_IDLE: begin
            in_ready = 1'b1;
         end
         ST_ROUND: begin
            rk_idx = round_q;
         end
         ST_DONE: begin
            out_valid = 1'b1;
         end
         default: begin
            rk_idx = LAST_RK_IDX;
         end
      endcase
   end

   assign plaintext = state_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Self-checking bench for aes_inv_cipher_iter. The reference is a forward
// AES-128 model (S-box built by the generator recurrence, key expansion,
// encrypt) plus published vectors.
module tb_aes_inv_cipher_iter;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] ciphertext;
   logic [3:0]   rk_idx;
   logic [127:0] rk;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] plaintext;

   aes_inv_cipher_iter dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ciphertext (ciphertext),
      .rk_idx     (rk_idx),
      .rk         (rk),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .plaintext  (plaintext)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [127:0] rk_tab [0:10];
   logic [127:0] mdl_rk [0:10];
   logic [7:0]   sbox [0:255];

   // Combinational key-schedule storage.
   always_comb begin
      rk = 128'd0;
      if (rk_idx <= 4'd10) rk = rk_tab[rk_idx];
   end

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [7:0] rl(input logic [7:0] v, input int s);
      logic [15:0] w;
      w = {v, v} << s;
      return w[15:8];
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   task automatic build_sbox();
      logic [7:0] p;
      logic [7:0] q;
      logic [7:0] x;
      p = 8'h01;
      q = 8'h01;
      for (int k = 0; k < 255; k++) begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
         sbox[p] = x ^ 8'h63;
      end
      sbox[0] = 8'h63;
   endtask

   task automatic expand_key(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i - 1];
         if (i % 4 == 0) begin
            t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i - 4] ^ t;
      end
      for (int r = 0; r < 11; r++) mdl_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
   endtask

   // SubBytes followed by ShiftRows (out[r][c] = in[r][(c+r) mod 4]).
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [7:0]   b [0:15];
      logic [127:0] o;
      for (int j = 0; j < 16; j++) b[j] = s[127 - 8 * j -: 8];
      o = 128'd0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127 - 8 * (4 * c + r) -: 8] = sbox[b[4 * ((c + r) % 4) + r]];
      return o;
   endfunction

   function automatic logic [127:0] mix_cols(input logic [127:0] s);
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] o;
      o = 128'd0;
      for (int c = 0; c < 4; c++) begin
         {a0, a1, a2, a3} = s[127 - 32 * c -: 32];
         o[127 - 32 * c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                  a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                  a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                  xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
      end
      return o;
   endfunction

   function automatic logic [127:0] model_encrypt(input logic [127:0] pt);
      logic [127:0] s;
      s = pt ^ mdl_rk[0];
      for (int r = 1; r <= 10; r++) begin
         s = sub_shift(s);
         if (r != 10) s = mix_cols(s);
         s = s ^ mdl_rk[r];
      end
      return s;
   endfunction

   // Runs one block using the round keys in mdl_rk. Latency is reported in
   // cycles counting the cycle that starts on the accept edge as cycle 1.
   task automatic do_block(input logic [127:0] ct_v, input logic [127:0] pt_exp, input bit keep_valid,
                           input bit chk_seq, input string tag, output int acc_cyc);
      int n;
      bit seq_ok;
      for (int i = 0; i < 11; i++) rk_tab[i] = mdl_rk[i];
      ciphertext = ct_v;
      in_valid   = 1'b1;
      n = 0;
      while (!in_ready && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_ready"}, in_ready, 1'b1);
      seq_ok = (rk_idx == 4'd10);
      @(posedge clk); #1;
      acc_cyc = cyc;
      if (!keep_valid) begin
         in_valid   = 1'b0;
         ciphertext = ~ct_v;
      end
      n = 0;
      while (!out_valid && n < 30) begin
         if (rk_idx != 4'(9 - n)) seq_ok = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      if (rk_idx != 4'd10) seq_ok = 1'b0;
      check({tag, "_latency"}, 128'(n + 1), 128'd11);
      if (chk_seq) check({tag, "_rk_idx_seq"}, seq_ok, 1'b1);
      check({tag, "_plaintext"}, plaintext, pt_exp);
      if (out_ready) begin
         @(posedge clk); #1;
      end
   endtask

   typedef struct {
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
   } vec_t;

   vec_t vecs [0:3];

   initial begin
      int acc;
      int prev_acc;
      int n;
      bit ok;
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] ct;

      vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
      vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};
      vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'h6bc1bee22e409f96e93d7e117393172a};
      vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hf5d3d58503b9699de785895a96fdbaaf, 128'hae2d8a571e03ac9c9eb76fac45af8e51};

      build_sbox();
      for (int i = 0; i < 11; i++) rk_tab[i] = 128'd0;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      ciphertext = 128'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready", in_ready, 1'b1);
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_plaintext", plaintext, 128'd0);
      check("reset_rk_idx", rk_idx, 4'd10);
      rst = 1'b0;

      // Internal helper functions.
      check("unit_invsub_63", aes_inv_cipher_iter_pkg::inv_sub_byte(8'h63), 8'h00);
      check("unit_invsub_00", aes_inv_cipher_iter_pkg::inv_sub_byte(8'h00), 8'h52);
      check("unit_invmixcol", aes_inv_cipher_iter_pkg::inv_mix_column(32'h8e4da1bc), 32'hdb135345);
      check("unit_invshift", aes_inv_cipher_iter_pkg::inv_shift_rows(128'h000102030405060708090a0b0c0d0e0f),
            128'h000d0a0704010e0b0805020f0c090603);

      // Reference model against published values.
      expand_key(vecs[0].key);
      check("model_rk10", mdl_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
      for (int v = 0; v < 4; v++) begin
         expand_key(vecs[v].key);
         check($sformatf("model_enc%0d", v), model_encrypt(vecs[v].pt), vecs[v].ct);
      end

      // Directed vectors.
      for (int v = 0; v < 4; v++) begin
         expand_key(vecs[v].key);
         do_block(vecs[v].ct, vecs[v].pt, 1'b0, v == 0, $sformatf("vec%0d", v), acc);
      end

      // Backpressure: DONE held for 20 cycles with a competing in_valid.
      expand_key(vecs[0].key);
      out_ready = 1'b0;
      do_block(vecs[0].ct, vecs[0].pt, 1'b0, 1'b0, "bp", acc);
      expand_key(vecs[1].key);
      in_valid = 1'b1;
      ciphertext = vecs[1].ct;
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (!(out_valid === 1'b1 && plaintext === vecs[0].pt && in_ready === 1'b0 && rk_idx === 4'd10)) ok = 1'b0;
      end
      check("bp_hold_stable", ok, 1'b1);
      out_ready = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("bp_release_in_ready", in_ready, 1'b1);
      check("bp_release_out_valid", out_valid, 1'b0);
      do_block(vecs[1].ct, vecs[1].pt, 1'b0, 1'b0, "bp_next", acc);

      // Reset in the middle of round 5.
      expand_key(vecs[2].key);
      for (int i = 0; i < 11; i++) rk_tab[i] = mdl_rk[i];
      ciphertext = vecs[2].ct;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (rk_idx != 4'd5 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("mid_reach_round5", rk_idx, 4'd5);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_rst_in_ready", in_ready, 1'b1);
      check("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_plaintext", plaintext, 128'd0);
      check("mid_rst_rk_idx", rk_idx, 4'd10);
      do_block(vecs[2].ct, vecs[2].pt, 1'b0, 1'b0, "after_rst", acc);

      // Reset coincident with a handshake: the block must be dropped.
      in_valid = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b0;
      check("rst_vs_accept_in_ready", in_ready, 1'b1);
      ok = 1'b1;
      for (int i = 0; i < 14; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) ok = 1'b0;
      end
      check("rst_vs_accept_no_output", ok, 1'b1);

      // Back-to-back random blocks, in_valid and out_ready held high.
      prev_acc = 0;
      for (int b = 0; b < 50; b++) begin
         key = {$urandom(), $urandom(), $urandom(), $urandom()};
         pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
         expand_key(key);
         ct = model_encrypt(pt);
         do_block(ct, pt, 1'b1, 1'b0, $sformatf("rnd%0d", b), acc);
         if (b > 0) check($sformatf("rnd%0d_spacing", b), 128'(acc - prev_acc), 128'd12);
         prev_acc = acc;
      end
      in_valid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
Iterative AES-128 decryption core; inverse counterpart of the encryption round datapath. Computes one inverse round per clock (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns). Round keys are fetched by index from the existing key-schedule storage. Sits between the key expansion block and the system datapath, with valid/ready handshakes on input and output.

Parameters:
None. The block is AES-128 only; Nr is fixed at 10 and round keys are indexed 0..10.

Ports:
clk         input   1    clock
rst         input   1    reset
in_valid    input   1    ciphertext valid
in_ready    output  1    core can accept ciphertext
ciphertext  input   128  block to decrypt
rk_idx      output  4    round-key index requested
rk          input   128  round key for rk_idx, combinational same-cycle lookup
out_valid   output  1    plaintext valid
out_ready   input   1    downstream accepts plaintext
plaintext   output  128  decrypted block

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Byte order: FIPS-197 byte j (row j%4, col j/4) occupies bits [127-8j:120-8j]. This is the same MSB-first packing used by the encryption path.
- InvShiftRows: s'[r][c] = s[r][(c-r) mod 4]. Row 0 is unchanged; row r rotates right by r columns.
- InvSubBytes: FIPS inverse S-box on all 16 bytes, combinational, table or GF(2^8) inversion.
- InvMixColumns: per column, matrix {0e,0b,0d,09} circulant over GF(2^8), reduction polynomial 0x11b.
- FSM states and rules:
  - IDLE: in_ready=1, rk_idx=10. On in_valid: state_reg <= ciphertext ^ rk, round <= 9, go to ROUND. No action otherwise.
  - ROUND: in_ready=0, rk_idx=round.
  - ROUND, round 9..1: state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ rk), round <= round-1.
  - ROUND, round 0: state_reg <= InvSubBytes(InvShiftRows(state_reg)) ^ rk; go to DONE.
  - DONE: out_valid=1, in_ready=0, rk_idx=10. plaintext=state_reg, held stable while out_ready=0. On out_ready, go to IDLE.
- Latency: handshake accepted on clock edge T. ROUND occupies cycles T+1..T+10. out_valid is high from cycle T+11. Minimum throughput is 1 block per 12 cycles, since there is no accept in DONE.
- in_valid in ROUND/DONE is ignored, and ciphertext is not sampled. Input is sampled only on the accepting edge; later changes to ciphertext have no effect.
- rk must be a pure combinational function of rk_idx. The core never holds rk_idx outside 0..10.
- plaintext always equals state_reg; it is meaningful only while out_valid=1.
- Reset values (any state, including mid-operation): FSM=IDLE, state_reg=0, round=0, in_ready=1, out_valid=0, plaintext=0, rk_idx=10. A block in flight is discarded with no partial output.
- rst asserted on the same edge as an input handshake: reset wins and the block is not accepted.
- out_ready while not in DONE has no effect.

Test Plan:
- Key 000102030405060708090a0b0c0d0e0f (bench model supplies the 11 round keys; rk[10]=13111d7fe3944a17f307a78b4d2b30c5), ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a. Required: plaintext 00112233445566778899aabbccddeeff, out_valid rising exactly 11 cycles after the accept edge, and rk_idx sequence 10,9,8,...,0.
- Key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32. Required: plaintext 3243f6a8885a308d313198a2e0370734.
- Backpressure: hold out_ready=0 for 20 cycles after DONE. Required: out_valid and plaintext stay stable, in_ready=0, and a new in_valid with a different block is not accepted. Releasing out_ready gives IDLE the next cycle and in_ready=1.
- Reset mid-operation: assert rst at ROUND with round=5. Required: next cycle in_ready=1, out_valid=0, plaintext=0, rk_idx=10. A following block decrypts correctly.
- Back-to-back: 50 random key/plaintext pairs encrypted by the reference model, with in_valid always high and out_ready always high. Required: every output matches and blocks are spaced 12 cycles apart.
- Unit checks on internal functions:
  - InvSubBytes: 0x63 -> 0x00 and 0x00 -> 0x52.
  - InvMixColumns column: 8e4da1bc -> db135345.
  - InvShiftRows of 000102...0f: 000d0a0704010e0b0805020f0c090603.
